// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - field-source and instruction-memory write signals of the loader
interface inst_loader_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [1:0]        in_src1;
  logic [1:0]        in_src2;
  logic [1:0]        in_dest;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;

  // master: the loader itself; slave: field source plus memory around it
  modport master (
    input  in_valid, in_op, in_src1, in_src2, in_dest, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_op, in_src1, in_src2, in_dest, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - packs instruction fields into bytes and writes them to instruction memory
module inst_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  inst_loader_if.master   bus,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [ADDR_W:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              last_seen_q, last_seen_d;
  logic [7:0]        fifo_q [DEPTH];

  logic       fifo_empty;
  logic       fifo_full;
  logic       active;
  logic       push;
  logic       pop;
  logic [7:0] enc_byte;

  assign enc_byte = {bus.in_op, bus.in_src1, bus.in_src2, bus.in_dest};

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign active        = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign bus.in_ready  = (state_q == S_LOAD) && !fifo_full && !last_seen_q;
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.mem_we    = active && !fifo_empty;
  assign pop           = bus.mem_we && bus.mem_ready;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.mem_we ? fifo_q[rd_ptr_q[PTR_W-1:0]] : 8'h00;

  assign busy     = active;
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;
  assign count    = count_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    last_seen_d = last_seen_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          addr_d      = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
          if (bus.in_last) begin
            last_seen_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // An empty FIFO means mem_we is low, so no write can be completing.
        if (fifo_empty) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      addr_d   = addr_q + ADDR_W'(1);
      if (addr_q == '1) begin
        overflow_d = 1'b1;
      end
      if (count_q != '1) begin
        count_d = count_q + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Entry storage needs no reset: reads are gated by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_byte;
    end
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Producer end of the CPU's 8-bit instruction format: packs op/src1/src2/dest fields into instruction bytes and writes them sequentially into instruction memory from address 0.
- Fetch/decode consume these bytes.
- Upstream is a valid/ready field source (testbench, UART front end). Downstream is the instruction memory write port with a ready back-pressure signal.
- Contains a small FIFO so the field source and the memory can stall independently.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 4, instruction memory address width; memory holds 2^ADDR_W bytes.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- start  input  1  single-cycle pulse; begins a load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader accepts bundle this cycle.
- in_op  input  2  opcode field.
- in_src1  input  2  source-1 register address.
- in_src2  input  2  source-2 register address.
- in_dest  input  2  destination register address.
- in_last  input  1  bundle is the final instruction of the program.
- mem_we  output  1  write request to instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  encoded instruction.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  high in LOAD or DRAIN.
- done  output  1  high in DONE.
- overflow  output  1  sticky; address wrapped past 2^ADDR_W-1.
- count  output  ADDR_W+1  instructions written this session; saturates at all-ones.

Behaviour:
- Encoding: inst = {op, src1, src2, dest}, i.e. op at [7:6], src1 at [5:4], src2 at [3:2], dest at [1:0]. Pure bit concatenation, no arithmetic.
- Reset (reset==0 at a clock edge):
  - state=IDLE; FIFO emptied; last_seen=0.
  - mem_addr=0, count=0, overflow=0.
  - in_ready=0, mem_we=0, busy=0, done=0.
  - mem_wdata is don't-care but driven as 0.
  - Reset mid-session aborts it; no further writes are issued.
- States:
  - IDLE: in_ready=0, mem_we=0. start -> LOAD, clearing mem_addr, count, overflow, FIFO and last_seen.
  - LOAD: in_ready = !fifo_full && !last_seen.
    - Accept = in_valid && in_ready; pushes the encoded byte.
    - Accept with in_last=1 sets last_seen and moves to DRAIN.
  - DRAIN: in_ready=0; keeps writing. When the FIFO is empty and no write is completing -> DONE.
  - DONE: done=1, in_ready=0, mem_we=0. start -> LOAD with the same clearing as from IDLE.
- start is ignored in LOAD and DRAIN.
- Write side (LOAD and DRAIN):
  - mem_we = !fifo_empty; mem_wdata = FIFO head; mem_addr = address register.
  - A write completes when mem_we && mem_ready. On completion: pop, mem_addr+1 (modulo 2^ADDR_W), count+1 (saturating).
  - mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.
- Latency: a bundle accepted at edge N is presented on mem_wdata/mem_we in cycle N+1 at the earliest (registered FIFO, no bypass).
- Throughput: one accept and one write per cycle when unstalled.
- Full FIFO: in_ready=0 even if a pop occurs the same cycle (no same-cycle refill when full).
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy unchanged.
- Wrap: completion at mem_addr = 2^ADDR_W-1 sets overflow=1 (sticky until next start or reset). Address goes to 0 and loading continues, overwriting.
- in_valid while in IDLE or DONE: ignored, no accept.

Test Plan:
- Encode: start; one bundle op=1, src1=2, src2=3, dest=0, last=1; mem_ready=1.
  -> mem_we for one cycle, mem_addr=0, mem_wdata=8'h6C; then done=1, count=1.
- Burst: 3 bundles (3,0,1,2), (0,1,1,1), (2,3,0,1), last on the third; mem_ready=1.
  -> writes 8'hC6 @0, 8'h15 @1, 8'hB1 @2 on consecutive cycles; count=3; done.
- Back-pressure: mem_ready=0; offer 6 bundles.
  -> 4 accepted, then in_ready=0; mem_we held at addr 0 with stable data.
  -> Raise mem_ready: all 6 written in order to addr 0..5.
- Overflow: ADDR_W=4; load 17 bundles.
  -> 17th written at addr 0; overflow=1; count=17.
  -> Next start clears overflow and count.
- Reset mid-DRAIN: reset=0 with 2 entries pending.
  -> Next cycle mem_we=0, busy=0, count=0, FIFO empty.
  -> start then works normally.
- start pulsed during LOAD -> ignored; mem_addr and count continue uninterrupted.
